// File: rtl/pipeline_control_if.sv
// Signal bundle between the ID-stage instruction source and the pipeline control block.
// The instruction source uses the master view. The control block uses the slave view.
interface pipeline_control_if #(
  parameter int COUNT_W = 16
);
  logic [31:0]        instruccion;
  logic               flush;
  logic               RegDst;
  logic               ALUSrc;
  logic [1:0]         ALUOp;
  logic               MemRead;
  logic               MemWrite;
  logic               Branch;
  logic               RegWrite;
  logic               MemToReg;
  logic               stall;
  logic               illegal;
  logic [COUNT_W-1:0] bubble_count;

  modport master (
    output instruccion, flush,
    input  RegDst, ALUSrc, ALUOp, MemRead, MemWrite, Branch,
           RegWrite, MemToReg, stall, illegal, bubble_count
  );

  modport slave (
    input  instruccion, flush,
    output RegDst, ALUSrc, ALUOp, MemRead, MemWrite, Branch,
           RegWrite, MemToReg, stall, illegal, bubble_count
  );
endinterface

// File: rtl/pipeline_control.sv
// Control path for a 5-stage pipeline. It decodes the instruction in ID and carries the control bits through EX, MEM and WB.
// It also detects load-use hazards, which cause a stall, and a taken branch, which causes a flush.
module pipeline_control #(
  parameter int COUNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  pipeline_control_if.slave bus
);

  // control word layout: {RegDst, ALUSrc, ALUOp[1:0], MemRead, MemWrite, Branch, RegWrite, MemToReg}
  localparam logic [8:0] CTRL_RTYPE = 9'b1_0_10_0_0_0_1_0;
  localparam logic [8:0] CTRL_LW    = 9'b0_1_00_1_0_0_1_1;
  localparam logic [8:0] CTRL_SW    = 9'b0_1_00_0_1_0_0_0;
  localparam logic [8:0] CTRL_BEQ   = 9'b0_0_01_0_0_1_0_0;
  localparam logic [8:0] CTRL_ADDI  = 9'b0_1_00_0_0_0_1_0;

  logic [5:0]         op;
  logic [4:0]         rs;
  logic [4:0]         rt;
  logic [8:0]         ctrl_id;
  logic               id_uses_rt;
  logic               id_unknown;
  logic               stall;

  logic [8:0]         ex_ctrl;
  logic [4:0]         ex_rt;
  logic [4:0]         mem_ctrl;
  logic [1:0]         wb_ctrl;
  logic               illegal_q;
  logic [COUNT_W-1:0] bubble_count_q;
  logic               unused_bits;

  assign op          = bus.instruccion[31:26];
  assign rs          = bus.instruccion[25:21];
  assign rt          = bus.instruccion[20:16];
  assign unused_bits = ^bus.instruccion[15:0];

  always_comb begin
    ctrl_id    = '0;
    id_uses_rt = 1'b0;
    id_unknown = 1'b0;
    if (bus.instruccion != 32'd0) begin
      case (op)
        6'b000000: begin ctrl_id = CTRL_RTYPE; id_uses_rt = 1'b1; end
        6'b100011: ctrl_id = CTRL_LW;
        6'b101011: begin ctrl_id = CTRL_SW;    id_uses_rt = 1'b1; end
        6'b000100: begin ctrl_id = CTRL_BEQ;   id_uses_rt = 1'b1; end
        6'b001000: ctrl_id = CTRL_ADDI;
        default:   id_unknown = 1'b1;
      endcase
    end
  end

  // a flush squashes ID anyway, so it never stalls
  assign stall = ex_ctrl[4] && (ex_rt != 5'd0) && !bus.flush &&
                 ((ex_rt == rs) || ((ex_rt == rt) && id_uses_rt));

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_ctrl        <= '0;
      ex_rt          <= '0;
      mem_ctrl       <= '0;
      wb_ctrl        <= '0;
      illegal_q      <= 1'b0;
      bubble_count_q <= '0;
    end else begin
      if (bus.flush || stall) begin
        ex_ctrl <= '0;
        ex_rt   <= '0;
      end else begin
        ex_ctrl <= ctrl_id;
        ex_rt   <= rt;
      end
      mem_ctrl  <= bus.flush ? 5'd0 : ex_ctrl[4:0];
      wb_ctrl   <= mem_ctrl[1:0];
      // a stalled instruction is decoded again next cycle, so report it only once
      illegal_q <= id_unknown && !bus.flush && !stall;
      if (stall && (bubble_count_q != {COUNT_W{1'b1}}))
        bubble_count_q <= bubble_count_q + COUNT_W'(1);
    end
  end

  assign bus.RegDst       = ex_ctrl[8];
  assign bus.ALUSrc       = ex_ctrl[7];
  assign bus.ALUOp        = ex_ctrl[6:5];
  assign bus.MemRead      = mem_ctrl[4];
  assign bus.MemWrite     = mem_ctrl[3];
  assign bus.Branch       = mem_ctrl[2];
  assign bus.RegWrite     = wb_ctrl[1];
  assign bus.MemToReg     = wb_ctrl[0];
  assign bus.stall        = stall;
  assign bus.illegal      = illegal_q;
  assign bus.bubble_count = bubble_count_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed scoreboard bench for pipeline_control with a 2-bit bubble counter.
// The driver queues the expected outputs for each cycle. A monitor on the falling edge pops them and compares.
module tb_pipeline_control;
  localparam int CW = 2;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] ADD  = 32'h012A_4020;
  localparam logic [31:0] LW   = 32'h8D09_0004;
  localparam logic [31:0] LW0  = 32'h8D00_0004;
  localparam logic [31:0] ADD0 = 32'h0000_4020;
  localparam logic [31:0] BEQ  = 32'h1109_0003;
  localparam logic [31:0] ILL  = 32'hFC00_0000;
  localparam logic [31:0] SW   = 32'hAD09_0008;
  localparam logic [31:0] ADDI = 32'h2128_0005;

  typedef struct {
    logic [31:0]   instr;
    logic          flush;
    logic          rst;
    logic [10:0]   exp;
    logic [CW-1:0] cnt;
  } row_t;

  typedef struct {
    logic [10:0]   exp;
    logic [CW-1:0] cnt;
    int            idx;
  } sb_t;

  logic clock = 1'b0;
  logic reset;
  row_t rows[$];
  sb_t  sb_q[$];
  int   tests  = 0;
  int   errors = 0;

  pipeline_control_if #(.COUNT_W(CW)) bus_if ();

  pipeline_control #(.COUNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  // expected vector layout: {RegDst, ALUSrc, ALUOp, MemRead, MemWrite, Branch, RegWrite, MemToReg, stall, illegal}
  task automatic add_row(input logic [31:0] instr, input logic fl, input logic rs,
                         input logic [10:0] exp, input logic [CW-1:0] cnt);
    row_t r;
    r.instr = instr; r.flush = fl; r.rst = rs; r.exp = exp; r.cnt = cnt;
    rows.push_back(r);
  endtask

  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      logic [10:0] act;
      e = sb_q.pop_front();
      act = {bus_if.RegDst, bus_if.ALUSrc, bus_if.ALUOp, bus_if.MemRead, bus_if.MemWrite,
             bus_if.Branch, bus_if.RegWrite, bus_if.MemToReg, bus_if.stall, bus_if.illegal};
      tests++;
      if (act !== e.exp || bus_if.bubble_count !== e.cnt) begin
        errors++;
        $display("FAIL row%0d: got ctrl=%b count=%0d, expected ctrl=%b count=%0d",
                 e.idx, act, bus_if.bubble_count, e.exp, e.cnt);
      end
    end
  end

  initial begin
    // R-type through all stages
    add_row(NOP,  0, 0, 11'b0000_000_00_0_0, 0);
    add_row(ADD,  0, 0, 11'b0000_000_00_0_0, 0);
    add_row(NOP,  0, 0, 11'b1010_000_00_0_0, 0);
    add_row(NOP,  0, 0, 11'b0000_000_00_0_0, 0);
    add_row(NOP,  0, 0, 11'b0000_000_10_0_0, 0);
    // lw followed by a dependent add
    add_row(LW,   0, 0, 11'b0000_000_00_0_0, 0);
    add_row(ADD,  0, 0, 11'b0100_000_00_1_0, 0);
    add_row(ADD,  0, 0, 11'b0000_100_00_0_0, 1);
    add_row(NOP,  0, 0, 11'b1010_000_11_0_0, 1);
    add_row(NOP,  0, 0, 11'b0000_000_00_0_0, 1);
    add_row(NOP,  0, 0, 11'b0000_000_10_0_0, 1);
    // lw to $0 never stalls
    add_row(LW0,  0, 0, 11'b0000_000_00_0_0, 1);
    add_row(ADD0, 0, 0, 11'b0100_000_00_0_0, 1);
    add_row(NOP,  0, 0, 11'b1010_100_00_0_0, 1);
    add_row(NOP,  0, 0, 11'b0000_000_11_0_0, 1);
    add_row(NOP,  0, 0, 11'b0000_000_10_0_0, 1);
    // beq in MEM, lw in EX, add in ID, flush
    add_row(BEQ,  0, 0, 11'b0000_000_00_0_0, 1);
    add_row(LW,   0, 0, 11'b0001_000_00_0_0, 1);
    add_row(ADD,  1, 0, 11'b0100_001_00_0_0, 1);
    add_row(NOP,  0, 0, 11'b0000_000_00_0_0, 1);
    add_row(NOP,  0, 0, 11'b0000_000_00_0_0, 1);
    // unknown opcode, plain then flushed
    add_row(ILL,  0, 0, 11'b0000_000_00_0_0, 1);
    add_row(NOP,  0, 0, 11'b0000_000_00_0_1, 1);
    add_row(NOP,  0, 0, 11'b0000_000_00_0_0, 1);
    add_row(ILL,  1, 0, 11'b0000_000_00_0_0, 1);
    add_row(NOP,  0, 0, 11'b0000_000_00_0_0, 1);
    // repeated load-use stalls saturate the counter, then reset during a stall
    add_row(LW,   0, 0, 11'b0000_000_00_0_0, 1);
    add_row(ADD,  0, 0, 11'b0100_000_00_1_0, 1);
    add_row(ADD,  0, 0, 11'b0000_100_00_0_0, 2);
    add_row(LW,   0, 0, 11'b1010_000_11_0_0, 2);
    add_row(ADD,  0, 0, 11'b0100_000_00_1_0, 2);
    add_row(ADD,  0, 0, 11'b0000_100_10_0_0, 3);
    add_row(LW,   0, 0, 11'b1010_000_11_0_0, 3);
    add_row(ADD,  0, 0, 11'b0100_000_00_1_0, 3);
    add_row(ADD,  0, 0, 11'b0000_100_10_0_0, 3);
    add_row(LW,   0, 0, 11'b1010_000_11_0_0, 3);
    add_row(ADD,  0, 0, 11'b0100_000_00_1_0, 3);
    add_row(ADD,  0, 0, 11'b0000_100_10_0_0, 3);
    add_row(LW,   0, 0, 11'b1010_000_11_0_0, 3);
    add_row(ADD,  0, 1, 11'b0100_000_00_1_0, 3);
    add_row(NOP,  0, 0, 11'b0000_000_00_0_0, 0);
    // sw and addi through the pipe
    add_row(SW,   0, 0, 11'b0000_000_00_0_0, 0);
    add_row(ADDI, 0, 0, 11'b0100_000_00_0_0, 0);
    add_row(NOP,  0, 0, 11'b0100_010_00_0_0, 0);
    add_row(NOP,  0, 0, 11'b0000_000_00_0_0, 0);
    add_row(NOP,  0, 0, 11'b0000_000_10_0_0, 0);

    reset = 1'b1;
    bus_if.instruccion = NOP;
    bus_if.flush = 1'b0;
    repeat (2) @(posedge clock);

    for (int i = 0; i < rows.size(); i++) begin
      sb_t e;
      @(posedge clock);
      #1;
      reset              = rows[i].rst;
      bus_if.instruccion = rows[i].instr;
      bus_if.flush       = rows[i].flush;
      e.exp = rows[i].exp;
      e.cnt = rows[i].cnt;
      e.idx = i;
      sb_q.push_back(e);
    end

    repeat (2) @(posedge clock);
    tests++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
